// File: rtl/wu_frame_sync_if.sv
// rtl/wu_frame_sync_if.sv - wake-up frame sync signal bundle
interface wu_frame_sync_if #(
    parameter int CNT_W = 10
);
    logic             comp_out;
    logic             WU_valid;
    logic             abort;
    logic             payload;
    logic             T_0;
    logic             T_1;
    logic             WU_serviced;
    logic             data_clk_enb;
    logic             data_clk;
    logic             bit_strobe;
    logic [CNT_W-1:0] bit_idx;
    logic             frame_done;

    modport master (
        output comp_out, WU_valid, abort, payload,
        input  T_0, T_1, WU_serviced, data_clk_enb, data_clk, bit_strobe, bit_idx, frame_done
    );

    modport slave (
        input  comp_out, WU_valid, abort, payload,
        output T_0, T_1, WU_serviced, data_clk_enb, data_clk, bit_strobe, bit_idx, frame_done
    );
endinterface

// File: rtl/wu_frame_sync.sv
// rtl/wu_frame_sync.sv - comparator wake-up triggered serial frame generator
module wu_frame_sync #(
    parameter int DIV         = 100,
    parameter int FRAME_BITS  = 1000,
    parameter int PRE_BITS    = 192,
    parameter int SYNC_STAGES = 3,
    parameter int CNT_W       = $clog2(FRAME_BITS + 1)
) (
    input logic            clki,
    input logic            rst_n,
    wu_frame_sync_if.slave bus
);
    localparam int HALF = DIV / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0]    HALF_MAX = HW'(HALF - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] END_IDX  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] PRE_IDX  = CNT_W'(PRE_BITS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, fill_q;
    logic [HW-1:0]    half_q, half_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic dclk_q, dclk_d, enb_q, enb_d, srv_q, srv_d;
    logic t0_q, t0_d, t1_q, t1_d, stb_q, stb_d, done_q, done_d;
    logic trigger, wrap, data_bit;

    // fill_q marks stages holding real post-reset samples, so a level held
    // high across reset release is never mistaken for a rising edge.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.comp_out};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign trigger  = fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1] &&
                      sync_q[SYNC_STAGES-2] && bus.WU_valid;
    assign wrap     = (half_q == HALF_MAX);
    assign data_bit = (idx_q < PRE_IDX) ? 1'b0 : bus.payload;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            half_q  <= '0;
            idx_q   <= '0;
            dclk_q  <= 1'b0;
            enb_q   <= 1'b0;
            srv_q   <= 1'b0;
            t0_q    <= 1'b0;
            t1_q    <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            idx_q   <= idx_d;
            dclk_q  <= dclk_d;
            enb_q   <= enb_d;
            srv_q   <= srv_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        idx_d   = idx_q;
        dclk_d  = dclk_q;
        enb_d   = enb_q;
        srv_d   = srv_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        stb_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger && !bus.abort) begin
                    state_d = RUN;
                    enb_d   = 1'b1;
                    srv_d   = 1'b1;
                    dclk_d  = 1'b0;
                    idx_d   = '0;
                    half_d  = HALF_MAX;
                    t0_d    = 1'b0;
                    t1_d    = 1'b0;
                end
            end
            RUN: begin
                // Frame end is checked before abort so a coincident abort
                // still lets the completed frame report frame_done.
                if (wrap && dclk_q && idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    enb_d   = 1'b0;
                    dclk_d  = 1'b0;
                    srv_d   = 1'b0;
                    t0_d    = 1'b0;
                    t1_d    = 1'b0;
                    half_d  = '0;
                    idx_d   = END_IDX;
                    done_d  = 1'b1;
                end else if (bus.abort) begin
                    state_d = IDLE;
                    enb_d   = 1'b0;
                    dclk_d  = 1'b0;
                    srv_d   = 1'b0;
                    t0_d    = 1'b0;
                    t1_d    = 1'b0;
                    half_d  = '0;
                    idx_d   = '0;
                end else begin
                    half_d = wrap ? '0 : half_q + HW'(1);
                    if (wrap) begin
                        dclk_d = !dclk_q;
                        if (!dclk_q) begin
                            stb_d = 1'b1;
                            t1_d  = data_bit;
                            t0_d  = !data_bit;
                        end else begin
                            srv_d = 1'b0;
                            if (idx_q != END_IDX) idx_d = idx_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.T_0          = t0_q;
    assign bus.T_1          = t1_q;
    assign bus.WU_serviced  = srv_q;
    assign bus.data_clk_enb = enb_q;
    assign bus.data_clk     = dclk_q;
    assign bus.bit_strobe   = stb_q;
    assign bus.bit_idx      = idx_q;
    assign bus.frame_done   = done_q;
endmodule
